ysyx_24110015_axi4_sram_slave: RTL and testbench

AXI4 responder fronting an on-chip word SRAM, the slave-side counterpart to the core's AXI4 master port. Accepts INCR/FIXED bursts with IDs on independent write (AW/W/B) and read (AR/R) channel FSMs, applies byte strobes, and returns OKAY/SLVERR/DECERR per the rules below. It attaches to a xbar slave port or directly to the core's `io_master_*` bus in NPC simulation. It serves as the memory model for burst-capable masters such as a future ICache refill path.

---
 rtl/ysyx_24110015_axi_pkg.sv | 31 +++
 rtl/ysyx_24110015_sram_1r1w.sv | 32 +++
 rtl/ysyx_24110015_axi4_sram_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_ysyx_24110015_axi4_sram_slave.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110015_axi_pkg.sv
// rtl/ysyx_24110015_axi_pkg.sv - shared AXI4 response/burst codes, FSM states and address helpers
package ysyx_24110015_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  // Address of the following beat; FIXED (and anything not INCR) holds the address.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;
  endfunction

  // Only 1/2/4-byte beats on FIXED or INCR bursts are served.
  function automatic logic burst_ok(input logic [2:0] size, input logic [1:0] burst);
    return (size <= 3'd2) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
  endfunction

  // The code values already order DECERR > SLVERR > OKAY numerically.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ysyx_24110015_sram_1r1w.sv
// rtl/ysyx_24110015_sram_1r1w.sv - word SRAM with synchronous read and byte-enable write
module ysyx_24110015_sram_1r1w #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write: lanes not selected by wstrb keep their contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read; holds its value while re is low so a stalled beat stays stable.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ysyx_24110015_axi4_sram_slave.sv
// rtl/ysyx_24110015_axi4_sram_slave.sv - AXI4 burst responder in front of a 1R1W word SRAM
module ysyx_24110015_axi4_sram_slave
  import ysyx_24110015_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic [3:0]  s_awid,
  input  logic [7:0]  s_awlen,
  input  logic [2:0]  s_awsize,
  input  logic [1:0]  s_awburst,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wlast,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  output logic [3:0]  s_bid,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic [3:0]  s_rid
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  // Offset arithmetic is modulo 2^32, so addresses below BASE_ADDR land far above SPAN.
  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [1:0] beat_resp(input logic legal, input logic [31:0] a);
    if (!in_range(a)) return RESP_DECERR;
    return legal ? RESP_OKAY : RESP_SLVERR;
  endfunction

  logic        alive;
  w_state_t    w_state, w_state_nx;
  logic [31:0] w_addr;
  logic [3:0]  w_id;
  logic [7:0]  w_len;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic [8:0]  w_beat;
  logic [1:0]  w_resp, w_beat_resp;
  logic        aw_hs, w_hs, w_ok, w_in_len, w_len_err, mem_we;

  r_state_t    r_state, r_state_nx;
  logic [31:0] r_addr, r_next, rd_addr, mem_rdata;
  logic [3:0]  r_id;
  logic [7:0]  r_len, r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst, r_resp;
  logic        ar_hs, r_hs, r_ok, r_last, mem_re;

  // Keeps both ready outputs low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive <= 1'b0;
    else      alive <= 1'b1;
  end

  // ---------------- write channel ----------------
  assign aw_hs       = s_awvalid & s_awready;
  assign w_hs        = s_wvalid & s_wready;
  assign w_ok        = burst_ok(w_size, w_burst);
  assign w_in_len    = (w_beat <= {1'b0, w_len});
  assign w_len_err   = !w_in_len || (s_wlast && (w_beat != {1'b0, w_len}));
  assign w_beat_resp = worst_resp(beat_resp(w_ok, w_addr), w_len_err ? RESP_SLVERR : RESP_OKAY);
  assign mem_we      = w_hs && w_ok && w_in_len && in_range(w_addr);
  assign s_bresp     = s_bvalid ? w_resp : 2'b00;
  assign s_bid       = s_bvalid ? w_id : 4'h0;

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_state_nx;
  end

  // Write FSM next state and channel handshake outputs.
  always_comb begin
    w_state_nx = w_state;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_awready = alive;
        if (s_awvalid && alive) w_state_nx = W_DATA;
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) w_state_nx = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Burst context: latched on AW, advanced and response-accumulated on each W beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_addr  <= 32'h0;
      w_id    <= 4'h0;
      w_len   <= 8'h0;
      w_size  <= 3'h0;
      w_burst <= 2'h0;
      w_beat  <= 9'h0;
      w_resp  <= RESP_OKAY;
    end else if (aw_hs) begin
      w_addr  <= s_awaddr;
      w_id    <= s_awid;
      w_len   <= s_awlen;
      w_size  <= s_awsize;
      w_burst <= s_awburst;
      w_beat  <= 9'h0;
      w_resp  <= RESP_OKAY;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_size, w_burst);
      if (w_beat != 9'h100) w_beat <= w_beat + 9'd1;
      w_resp <= worst_resp(w_resp, w_beat_resp);
    end
  end

  // ---------------- read channel ----------------
  assign ar_hs  = s_arvalid & s_arready;
  assign r_hs   = s_rvalid & s_rready;
  assign r_ok   = burst_ok(r_size, r_burst);
  assign r_last = (r_beat == r_len);
  assign r_next = next_addr(r_addr, r_size, r_burst);
  assign r_resp = beat_resp(r_ok, r_addr);

  // The array read for the next beat is issued in the handshake cycle so beats run back-to-back.
  assign rd_addr = ar_hs ? s_araddr : r_next;
  assign mem_re  = ar_hs ? (burst_ok(s_arsize, s_arburst) && in_range(s_araddr))
                         : (r_hs && !r_last && r_ok && in_range(r_next));

  assign s_rresp = s_rvalid ? r_resp : 2'b00;
  assign s_rdata = (s_rvalid && (r_resp == RESP_OKAY)) ? mem_rdata : 32'h0;
  assign s_rlast = s_rvalid && r_last;
  assign s_rid   = s_rvalid ? r_id : 4'h0;

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_state_nx;
  end

  // Read FSM next state and channel handshake outputs.
  always_comb begin
    r_state_nx = r_state;
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_arready = alive;
        if (s_arvalid && alive) r_state_nx = R_DATA;
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready && r_last) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Read burst context: latched on AR, stepped on each accepted non-final beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= 32'h0;
      r_id    <= 4'h0;
      r_len   <= 8'h0;
      r_size  <= 3'h0;
      r_burst <= 2'h0;
      r_beat  <= 8'h0;
    end else if (ar_hs) begin
      r_addr  <= s_araddr;
      r_id    <= s_arid;
      r_len   <= s_arlen;
      r_size  <= s_arsize;
      r_burst <= s_arburst;
      r_beat  <= 8'h0;
    end else if (r_hs && !r_last) begin
      r_addr <= r_next;
      r_beat <= r_beat + 8'd1;
    end
  end

  ysyx_24110015_sram_1r1w #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk  (clk),
    .re   (mem_re),
    .raddr(word_idx(rd_addr)),
    .rdata(mem_rdata),
    .we   (mem_we),
    .waddr(word_idx(w_addr)),
    .wstrb(s_wstrb),
    .wdata(s_wdata)
  );

endmodule

// File: tb/tb_ysyx_24110015_axi4_sram_slave.sv
// tb/tb_ysyx_24110015_axi4_sram_slave.sv - self-checking bench for the AXI4 SRAM responder
module tb_ysyx_24110015_axi4_sram_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_awvalid = 0, s_awready;
  logic [31:0] s_awaddr = 0;
  logic [3:0]  s_awid = 0;
  logic [7:0]  s_awlen = 0;
  logic [2:0]  s_awsize = 0;
  logic [1:0]  s_awburst = 0;
  logic        s_wvalid = 0, s_wready;
  logic [31:0] s_wdata = 0;
  logic [3:0]  s_wstrb = 0;
  logic        s_wlast = 0;
  logic        s_bvalid, s_bready = 0;
  logic [1:0]  s_bresp;
  logic [3:0]  s_bid;
  logic        s_arvalid = 0, s_arready;
  logic [31:0] s_araddr = 0;
  logic [3:0]  s_arid = 0;
  logic [7:0]  s_arlen = 0;
  logic [2:0]  s_arsize = 0;
  logic [1:0]  s_arburst = 0;
  logic        s_rvalid, s_rready = 0;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;

  ysyx_24110015_axi4_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference memory: word index -> value, only for words the bench has written.
  logic [31:0] model [int unsigned];

  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  int          b_lat;
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  int          rd_n, rd_gaps, rd_lat;

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b01) return start + 32'(i) * (32'd1 << size);
    return start;
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] size,
                                          input logic [1:0] burst);
    if (!in_rng(a)) return 2'b11;
    if (size > 3'd2 || burst > 2'b01) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int unsigned k;
    k = (a - BASE) >> 2;
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (exp_resp(a, size, burst) == 2'b00) ? model_rd(a) : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned k;
    logic [31:0] w;
    k = (a - BASE) >> 2;
    w = model.exists(k) ? model[k] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model[k] = w;
  endtask

  // Applies the beats of a burst that the memory actually stores (legal, in range, within len).
  task automatic model_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if (i <= len && exp_resp(beat_addr(addr, i, size, burst), size, burst) == 2'b00)
        model_write(beat_addr(addr, i, size, burst), wr_data[i], wr_strb[i]);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input int last_at, input bit stall);
    int n;
    bit hs;
    s_awaddr = addr; s_awid = id; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    n = 0;
    while (!s_awready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    s_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
      s_wdata = wr_data[i]; s_wstrb = wr_strb[i]; s_wlast = (i == last_at); s_wvalid = 1'b1;
      n = 0;
      while (!s_wready && n < 200) begin @(negedge clk); n++; end
      @(negedge clk);
      s_wvalid = 1'b0; s_wlast = 1'b0;
    end
    b_lat = 0;
    while (!s_bvalid && b_lat < 200) begin @(negedge clk); b_lat++; end
    b_resp = 2'b01; b_id = 4'hx;
    n = 0; hs = 0;
    while (!hs && n < 200) begin
      s_bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = s_bvalid && s_bready;
      if (hs) begin b_resp = s_bresp; b_id = s_bid; end
      @(negedge clk); n++;
    end
    s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit stall);
    int n;
    bit held;
    logic [38:0] hold_v;
    s_araddr = addr; s_arid = id; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    s_arvalid = 1'b0;
    rd_lat = 0;
    while (!s_rvalid && rd_lat < 200) begin @(negedge clk); rd_lat++; end
    rd_n = 0; rd_gaps = 0; held = 0; n = 0; hold_v = '0;
    while (rd_n < int'(len) + 1 && n < 2000) begin
      s_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_rvalid) begin
        if (held) begin
          total++;
          if ({s_rdata, s_rresp, s_rlast, s_rid} !== hold_v) begin
            bad++;
            $display("FAIL r_stable beat %0d: got %h want %h", rd_n,
                     {s_rdata, s_rresp, s_rlast, s_rid}, hold_v);
          end
        end
        if (s_rready) begin
          rd_data[rd_n] = s_rdata; rd_resp[rd_n] = s_rresp;
          rd_last[rd_n] = s_rlast; rd_id[rd_n] = s_rid;
          rd_n++; held = 0;
        end else begin
          held = 1; hold_v = {s_rdata, s_rresp, s_rlast, s_rid};
        end
      end else begin
        rd_gaps++;
      end
      @(negedge clk); n++;
    end
    s_rready = 1'b0;
    total++;
    if (rd_n !== int'(len) + 1) begin
      bad++; $display("FAIL r_beats: got %0d want %0d", rd_n, int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({s_awready, s_wready, s_bvalid, s_bresp, s_bid, s_arready, s_rvalid, s_rdata,
         s_rresp, s_rlast, s_rid} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero want all 0");
    end
    rst = 1'b1;
    #1;
    total++;
    if ({s_awready, s_arready} !== 2'b00) begin
      bad++; $display("FAIL ready_before_edge: got %b want 00", {s_awready, s_arready});
    end
    @(negedge clk);
    total++;
    if ({s_awready, s_arready, s_wready, s_bvalid, s_rvalid} !== 5'b11000) begin
      bad++; $display("FAIL ready_after_edge: got %b want 11000",
                      {s_awready, s_arready, s_wready, s_bvalid, s_rvalid});
    end
  endtask

  task automatic test_single();
    logic [3:0] id;
    id = 4'($urandom);
    wr_data[0] = 32'hDEAD_BEEF; wr_strb[0] = 4'hF;
    do_write(32'h8000_0010, id, 8'd0, 3'd2, 2'b01, 1, 0, 0);
    model_burst(32'h8000_0010, 0, 3'd2, 2'b01, 1);
    total++; if (b_resp !== 2'b00) begin bad++; $display("FAIL single_bresp: got %b want 00", b_resp); end
    total++; if (b_id !== id) begin bad++; $display("FAIL single_bid: got %h want %h", b_id, id); end
    total++; if (b_lat !== 0) begin bad++; $display("FAIL single_blat: got %0d want 0", b_lat); end
    do_read(32'h8000_0010, ~id, 8'd0, 3'd2, 2'b01, 0);
    total++; if (rd_data[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rdata: got %h want deadbeef", rd_data[0]); end
    total++; if (rd_last[0] !== 1'b1) begin bad++; $display("FAIL single_rlast: got %b want 1", rd_last[0]); end
    total++; if (rd_resp[0] !== 2'b00) begin bad++; $display("FAIL single_rresp: got %b want 00", rd_resp[0]); end
    total++; if (rd_lat !== 0) begin bad++; $display("FAIL single_rlat: got %0d want 0", rd_lat); end
    total++; if (rd_id[0] !== ~id) begin bad++; $display("FAIL single_rid: got %h want %h", rd_id[0], ~id); end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(8'h11 * (i + 1)); wr_strb[i] = 4'hF; end
    do_write(32'h8000_0100, 4'h2, 8'd3, 3'd2, 2'b01, 4, 3, 0);
    model_burst(32'h8000_0100, 3, 3'd2, 2'b01, 4);
    total++; if (b_resp !== 2'b00) begin bad++; $display("FAIL incr_bresp: got %b want 00", b_resp); end
    do_read(32'h8000_0100, 4'h5, 8'd3, 3'd2, 2'b01, 0);
    total++; if (rd_gaps !== 0) begin bad++; $display("FAIL incr_gaps: got %0d want 0", rd_gaps); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({rd_data[i], rd_resp[i], rd_last[i], rd_id[i]} !== {32'(8'h11 * (i + 1)), 2'b00, (i == 3), 4'h5}) begin
        bad++; $display("FAIL incr_beat%0d: got %h/%b/%b/%h want %h/00/%b/5", i, rd_data[i],
                        rd_resp[i], rd_last[i], rd_id[i], 32'(8'h11 * (i + 1)), (i == 3));
      end
    end
  endtask

  task automatic test_strobe_fixed();
    wr_data[0] = 32'hFFFF_FFFF; wr_strb[0] = 4'hF;
    do_write(32'h8000_0200, 4'h1, 8'd0, 3'd2, 2'b01, 1, 0, 0);
    model_burst(32'h8000_0200, 0, 3'd2, 2'b01, 1);
    wr_data[0] = 32'h0000_00AA; wr_strb[0] = 4'h1;
    wr_data[1] = 32'hBB00_0000; wr_strb[1] = 4'h8;
    do_write(32'h8000_0200, 4'h1, 8'd1, 3'd2, 2'b00, 2, 1, 0);
    model_burst(32'h8000_0200, 1, 3'd2, 2'b00, 2);
    total++; if (b_resp !== 2'b00) begin bad++; $display("FAIL fixed_bresp: got %b want 00", b_resp); end
    do_read(32'h8000_0200, 4'h1, 8'd0, 3'd2, 2'b01, 0);
    total++; if (rd_data[0] !== 32'hBBFF_FFAA) begin bad++; $display("FAIL fixed_rdata: got %h want bbffffaa", rd_data[0]); end
  endtask

  task automatic test_errors();
    do_read(32'h0000_0000, 4'h3, 8'd0, 3'd2, 2'b01, 0);
    total++; if ({rd_resp[0], rd_data[0]} !== {2'b11, 32'h0}) begin bad++; $display("FAIL decerr_read: got %b/%h want 11/0", rd_resp[0], rd_data[0]); end
    wr_data[0] = 32'h1234_5678; wr_strb[0] = 4'hF;
    do_write(32'h8000_0010, 4'h4, 8'd0, 3'd3, 2'b01, 1, 0, 0);
    total++; if (b_resp !== 2'b10) begin bad++; $display("FAIL size3_bresp: got %b want 10", b_resp); end
    do_read(32'h8000_0010, 4'h4, 8'd0, 3'd2, 2'b01, 0);
    total++; if (rd_data[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL size3_unchanged: got %h want deadbeef", rd_data[0]); end
    wr_data[0] = 32'h0000_5555; wr_strb[0] = 4'hF;
    do_write(32'h8000_0300, 4'h6, 8'd1, 3'd2, 2'b01, 1, 0, 0);
    model_burst(32'h8000_0300, 1, 3'd2, 2'b01, 1);
    total++; if (b_resp !== 2'b10) begin bad++; $display("FAIL early_wlast: got %b want 10", b_resp); end
    wr_data[0] = 32'hCAFE_F00D; wr_data[1] = 32'h0BAD_BEEF; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    do_write(32'h8000_3FFC, 4'h7, 8'd1, 3'd2, 2'b01, 2, 1, 0);
    model_burst(32'h8000_3FFC, 1, 3'd2, 2'b01, 2);
    total++; if (b_resp !== 2'b11) begin bad++; $display("FAIL top_bresp: got %b want 11", b_resp); end
    do_read(32'h8000_3FFC, 4'h7, 8'd1, 3'd2, 2'b01, 0);
    total++;
    if ({rd_resp[0], rd_data[0], rd_resp[1], rd_data[1], rd_last[1]} !== {2'b00, 32'hCAFE_F00D, 2'b11, 32'h0, 1'b1}) begin
      bad++; $display("FAIL top_read: got %b/%h %b/%h/%b want 00/cafef00d 11/0/1", rd_resp[0],
                      rd_data[0], rd_resp[1], rd_data[1], rd_last[1]);
    end
    do_read(32'h8000_0100, 4'h8, 8'd1, 3'd2, 2'b10, 0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({rd_resp[i], rd_data[i]} !== {2'b10, 32'h0}) begin
        bad++; $display("FAIL wrap_beat%0d: got %b/%h want 10/0", i, rd_resp[i], rd_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [8];
    for (int i = 0; i < 8; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
    do_write(32'h8000_0400, 4'h9, 8'd7, 3'd2, 2'b01, 8, 7, 0);
    model_burst(32'h8000_0400, 7, 3'd2, 2'b01, 8);
    for (int i = 0; i < 8; i++) exp[i] = model_rd(32'h8000_0400 + 32'(4 * i));
    for (int i = 0; i < 8; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
    fork
      do_write(32'h8000_0800, 4'hA, 8'd7, 3'd2, 2'b01, 8, 7, 1);
      do_read(32'h8000_0400, 4'hB, 8'd7, 3'd2, 2'b01, 1);
    join
    model_burst(32'h8000_0800, 7, 3'd2, 2'b01, 8);
    total++; if ({b_resp, b_id} !== {2'b00, 4'hA}) begin bad++; $display("FAIL ovl_b: got %b/%h want 00/a", b_resp, b_id); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({rd_data[i], rd_id[i], rd_last[i]} !== {exp[i], 4'hB, (i == 7)}) begin
        bad++; $display("FAIL ovl_r%0d: got %h/%h/%b want %h/b/%b", i, rd_data[i], rd_id[i], rd_last[i], exp[i], (i == 7));
      end
    end
    do_read(32'h8000_0800, 4'hC, 8'd7, 3'd2, 2'b01, 0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rd_data[i] !== model_rd(32'h8000_0800 + 32'(4 * i))) begin
        bad++; $display("FAIL ovl_w%0d: got %h want %h", i, rd_data[i], model_rd(32'h8000_0800 + 32'(4 * i)));
      end
    end
    // Same word, same cycle: the read issued alongside the write sees the old value.
    wr_data[0] = 32'h0101_0101; wr_strb[0] = 4'hF;
    do_write(32'h8000_0500, 4'h1, 8'd0, 3'd2, 2'b01, 1, 0, 0);
    model_burst(32'h8000_0500, 0, 3'd2, 2'b01, 1);
    s_awaddr = 32'h8000_0500; s_awlen = 0; s_awsize = 3'd2; s_awburst = 2'b01; s_awvalid = 1;
    for (int n = 0; n < 50 && !s_awready; n++) @(negedge clk);
    @(negedge clk);
    s_awvalid = 0;
    s_wdata = 32'h0202_0202; s_wstrb = 4'hF; s_wlast = 1; s_wvalid = 1;
    s_araddr = 32'h8000_0500; s_arlen = 0; s_arsize = 3'd2; s_arburst = 2'b01; s_arid = 4'h3; s_arvalid = 1;
    total++; if ({s_wready, s_arready} !== 2'b11) begin bad++; $display("FAIL same_cycle_ready: got %b want 11", {s_wready, s_arready}); end
    @(negedge clk);
    s_wvalid = 0; s_wlast = 0; s_arvalid = 0;
    total++; if ({s_rvalid, s_rdata} !== {1'b1, 32'h0101_0101}) begin bad++; $display("FAIL same_cycle_old: got %b/%h want 1/01010101", s_rvalid, s_rdata); end
    s_rready = 1; s_bready = 1;
    @(negedge clk);
    s_rready = 0; s_bready = 0;
    model_write(32'h8000_0500, 32'h0202_0202, 4'hF);
    do_read(32'h8000_0500, 4'h3, 8'd0, 3'd2, 2'b01, 0);
    total++; if (rd_data[0] !== 32'h0202_0202) begin bad++; $display("FAIL same_cycle_new: got %h want 02020202", rd_data[0]); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int len;
    for (int it = 0; it < 6; it++) begin
      len  = $urandom_range(0, 7);
      addr = BASE + 32'(4 * $urandom_range(12'h600, 12'hF00));
      for (int i = 0; i <= len; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      do_write(addr, 4'(it), 8'(len), 3'd2, 2'b01, len + 1, len, 0);
      model_burst(addr, len, 3'd2, 2'b01, len + 1);
      for (int i = 0; i <= len; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
      do_write(addr, 4'(it), 8'(len), 3'd2, 2'b01, len + 1, len, 1);
      model_burst(addr, len, 3'd2, 2'b01, len + 1);
      total++; if ({b_resp, b_id} !== {2'b00, 4'(it)}) begin bad++; $display("FAIL rnd_b%0d: got %b/%h want 00/%h", it, b_resp, b_id, 4'(it)); end
      do_read(addr, 4'(it + 1), 8'(len), 3'd2, 2'b01, 1);
      for (int i = 0; i <= len; i++) begin
        total++;
        if ({rd_data[i], rd_resp[i], rd_last[i]} !== {exp_rdata(beat_addr(addr, i, 3'd2, 2'b01), 3'd2, 2'b01), 2'b00, (i == len)}) begin
          bad++; $display("FAIL rnd_r%0d_%0d: got %h/%b/%b want %h/00/%b", it, i, rd_data[i], rd_resp[i], rd_last[i],
                          exp_rdata(beat_addr(addr, i, 3'd2, 2'b01), 3'd2, 2'b01), (i == len));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int got;
    s_araddr = 32'h8000_0400; s_arlen = 8'd7; s_arsize = 3'd2; s_arburst = 2'b01; s_arid = 4'hD; s_arvalid = 1;
    for (int n = 0; n < 50 && !s_arready; n++) @(negedge clk);
    @(negedge clk);
    s_arvalid = 0; s_rready = 1; got = 0;
    for (int n = 0; n < 50 && got < 2; n++) begin
      if (s_rvalid) got++;
      @(negedge clk);
    end
    total++; if ({s_rvalid, s_rdata} !== {1'b1, model_rd(32'h8000_0408)}) begin bad++; $display("FAIL mid_beat2: got %b/%h want 1/%h", s_rvalid, s_rdata, model_rd(32'h8000_0408)); end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({s_awready, s_wready, s_bvalid, s_bresp, s_bid, s_arready, s_rvalid, s_rdata,
         s_rresp, s_rlast, s_rid} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got nonzero want all 0");
    end
    s_rready = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (s_arready !== 1'b0) begin bad++; $display("FAIL mid_arready_early: got %b want 0", s_arready); end
    @(negedge clk);
    total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL mid_arready: got %b want 1", s_arready); end
    do_read(32'h8000_0404, 4'hE, 8'd0, 3'd2, 2'b01, 0);
    total++;
    if ({rd_data[0], rd_resp[0], rd_last[0], rd_id[0]} !== {model_rd(32'h8000_0404), 2'b00, 1'b1, 4'hE}) begin
      bad++; $display("FAIL mid_after: got %h/%b/%b/%h want %h/00/1/e", rd_data[0], rd_resp[0], rd_last[0], rd_id[0], model_rd(32'h8000_0404));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr();
    test_strobe_fixed();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
